// File: rtl/fd_circle_addr_seq.sv
// Streams SRAM addresses of the 16 radius-3 Bresenham circle pixels around a FAST9 candidate,
// then repeats the first EXTRA positions so a contiguous 9-run can be checked without buffering.
module fd_circle_addr_seq #(
    parameter int unsigned COLUMNS = 180,
    parameter int unsigned ROWS    = 120,
    parameter int unsigned EXTRA   = 8,
    parameter int unsigned XW      = $clog2(COLUMNS),
    parameter int unsigned YW      = $clog2(ROWS),
    parameter int unsigned ADDR_W  = $clog2(COLUMNS * ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XW-1:0]     in_x,
    input  logic [YW-1:0]     in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              rej
);

    localparam int unsigned BEATS = 16 + EXTRA;
    localparam int unsigned BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [XW-1:0] X_MIN = XW'(3);
    localparam logic [XW-1:0] X_MAX = XW'(COLUMNS - 4);
    localparam logic [YW-1:0] Y_MIN = YW'(3);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 4);
    localparam int C = int'(COLUMNS);

    typedef enum logic [1:0] {IDLE, EMIT, REJ} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] centre_q, centre_d;
    logic [3:0]        idx_q, idx_d;
    logic [BW-1:0]     beat_q, beat_d;

    logic                     border_c;
    logic signed [ADDR_W:0]   off_c;
    logic signed [ADDR_W:0]   addr_sum_c;

    // Signed address offset of circle position i, clockwise from 12 o'clock.
    function automatic logic signed [ADDR_W:0] circ_off(input logic [3:0] i);
        case (i)
            4'd0:    circ_off = (ADDR_W+1)'(-3 * C);
            4'd1:    circ_off = (ADDR_W+1)'(-3 * C + 1);
            4'd2:    circ_off = (ADDR_W+1)'(-2 * C + 2);
            4'd3:    circ_off = (ADDR_W+1)'(-C + 3);
            4'd4:    circ_off = (ADDR_W+1)'(3);
            4'd5:    circ_off = (ADDR_W+1)'(C + 3);
            4'd6:    circ_off = (ADDR_W+1)'(2 * C + 2);
            4'd7:    circ_off = (ADDR_W+1)'(3 * C + 1);
            4'd8:    circ_off = (ADDR_W+1)'(3 * C);
            4'd9:    circ_off = (ADDR_W+1)'(3 * C - 1);
            4'd10:   circ_off = (ADDR_W+1)'(2 * C - 2);
            4'd11:   circ_off = (ADDR_W+1)'(C - 3);
            4'd12:   circ_off = (ADDR_W+1)'(-3);
            4'd13:   circ_off = (ADDR_W+1)'(-C - 3);
            4'd14:   circ_off = (ADDR_W+1)'(-2 * C - 2);
            default: circ_off = (ADDR_W+1)'(-3 * C - 1);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            centre_q <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            centre_q <= centre_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
        end
    end

    // Next-state: accept/reject centre, advance beat on each consumed address.
    always_comb begin
        state_d  = state_q;
        centre_d = centre_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        border_c = (in_x < X_MIN) || (in_x > X_MAX) || (in_y < Y_MIN) || (in_y > Y_MAX);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (border_c) begin
                        state_d = REJ;
                    end else begin
                        state_d  = EMIT;
                        centre_d = ADDR_W'(in_y) * ADDR_W'(COLUMNS) + ADDR_W'(in_x);
                        idx_d    = '0;
                        beat_d   = '0;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        idx_d  = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Border rejection keeps the sum inside the frame, so truncation never wraps.
    always_comb begin
        off_c      = circ_off(idx_q);
        addr_sum_c = $signed({1'b0, centre_q}) + off_c;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign rej       = (state_q == REJ);
    assign out_idx   = idx_q;
    assign out_addr  = addr_sum_c[ADDR_W-1:0];
    assign out_last  = (state_q == EMIT) && (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_fd_circle_addr_seq.sv
// Directed bench for fd_circle_addr_seq: expected beats queued per centre, compared as the DUT emits them.
module tb_fd_circle_addr_seq;

    localparam int COLUMNS = 180;
    localparam int ROWS    = 120;
    localparam int EXTRA   = 8;
    localparam int XW      = $clog2(COLUMNS);
    localparam int YW      = $clog2(ROWS);
    localparam int ADDR_W  = $clog2(COLUMNS * ROWS);
    localparam int BEATS   = 16 + EXTRA;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XW-1:0]     in_x;
    logic [YW-1:0]     in_y;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              rej;

    typedef struct {
        int addr;
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;
    int   dx[16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int   dy[16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    fd_circle_addr_seq #(.COLUMNS(COLUMNS), .ROWS(ROWS), .EXTRA(EXTRA)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_idx(out_idx), .out_last(out_last), .rej(rej)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the full expected stream for a centre assumed to be inside the frame.
    task automatic push_centre(input int x, input int y);
        exp_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.idx  = b % 16;
            e.addr = (y + dy[b % 16]) * COLUMNS + (x + dx[b % 16]);
            e.last = (b == BEATS - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic accept(input int x, input int y);
        chk("in_ready_before_accept", 32'(in_ready), 1);
        chk("idle_no_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_x     = XW'(x);
        in_y     = YW'(y);
        tick();
        in_valid = 1'b0;
        in_x     = XW'(0);
        in_y     = YW'(0);
        chk("first_beat_latency", 32'(out_valid), 1);
        chk("in_ready_busy", 32'(in_ready), 0);
    endtask

    task automatic beat(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 0, 1);
        end else begin
            e = exp_q[0];
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_addr"}, 32'(out_addr), 32'(e.addr));
            chk({tag, "_idx"}, 32'(out_idx), 32'(e.idx));
            chk({tag, "_last"}, 32'(out_last), 32'(e.last));
            tick();
            void'(exp_q.pop_front());
        end
    endtask

    task automatic reject(input int x, input int y);
        chk("rej_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_x     = XW'(x);
        in_y     = YW'(y);
        tick();
        in_valid = 1'b0;
        chk("rej_pulse", 32'(rej), 1);
        chk("rej_no_valid", 32'(out_valid), 0);
        chk("rej_in_ready_low", 32'(in_ready), 0);
        tick();
        chk("rej_pulse_end", 32'(rej), 0);
        chk("rej_no_valid_after", 32'(out_valid), 0);
        chk("rej_back_idle", 32'(in_ready), 1);
    endtask

    initial begin
        int hs0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_rej", 32'(rej), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);

        // Centre (10,10) with spot checks against hand-computed addresses.
        hs0 = hs_cnt;
        push_centre(10, 10);
        accept(10, 10);
        for (int b = 0; b < BEATS; b++) begin
            if (b == 0)  chk("c10_idx0", 32'(out_addr), 1270);
            if (b == 4)  chk("c10_idx4", 32'(out_addr), 1813);
            if (b == 8)  chk("c10_idx8", 32'(out_addr), 2350);
            if (b == 12) chk("c10_idx12", 32'(out_addr), 1807);
            if (b == 15) chk("c10_idx15", 32'(out_addr), 1269);
            if (b == 16) chk("c10_wrap_idx0", 32'(out_addr), 1270);
            beat("c10");
        end
        chk("c10_handshakes", 32'(hs_cnt - hs0), 32'(BEATS));
        chk("c10_done_idle", 32'(out_valid), 0);

        // Border rejects.
        reject(2, 50);
        reject(177, 60);

        // Corner-most legal centre.
        push_centre(176, 116);
        accept(176, 116);
        for (int b = 0; b < BEATS; b++) beat("c176");

        // Backpressure at beat 3 for 5 cycles.
        hs0 = hs_cnt;
        push_centre(90, 60);
        accept(90, 60);
        for (int b = 0; b < BEATS; b++) begin
            if (b == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", 32'(out_valid), 1);
                    chk("stall_addr", 32'(out_addr), 32'(exp_q[0].addr));
                    chk("stall_idx", 32'(out_idx), 3);
                end
                out_ready = 1'b1;
            end
            beat("c90");
        end
        chk("stall_handshakes", 32'(hs_cnt - hs0), 32'(BEATS));

        // Reset mid-stream after beat 5.
        push_centre(50, 40);
        accept(50, 40);
        for (int b = 0; b < 6; b++) beat("c50");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_idx", 32'(out_idx), 0);

        // Back-to-back centres: the accept cycle is the single idle bubble.
        push_centre(20, 30);
        accept(20, 30);
        chk("restart_idx0", 32'(out_idx), 0);
        for (int b = 0; b < BEATS; b++) beat("c20");
        push_centre(100, 100);
        accept(100, 100);
        for (int b = 0; b < BEATS; b++) beat("c100");
        chk("end_idle", 32'(in_ready), 1);
        chk("end_queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
